// File: rtl/circ_pkg.sv
// Shared types and defaults for the CIRC front-end frame sequencer.
package circ_pkg;

  localparam int CIRC_WIDTH = 8;
  localparam int CIRC_WORDS = 32;

  typedef logic [CIRC_WORDS-1:0][CIRC_WIDTH-1:0] circ_frame_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    WAIT    = 2'd2
  } seq_state_t;

  // Symbol index width; at least one bit so single-word frames still elaborate.
  function automatic int circ_idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/circ_frame_assembler.sv
// Collect FSM: aligns on SYNC, writes byte-serial symbols into a shadow frame,
// and reports frame completion and alignment loss.
module circ_frame_assembler
  import circ_pkg::*;
#(
  parameter int WIDTH = CIRC_WIDTH,
  parameter int WORDS = CIRC_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sync,
  input  logic [WIDTH-1:0]            byte_in,
  input  logic                        byte_vld,
  output logic [WORDS-1:0][WIDTH-1:0] shadow,
  output logic                        complete,  // 1-cycle pulse, shadow holds a full frame
  output logic                        slip,      // registered alignment-loss pulse
  output logic                        slip_evt   // alignment loss happening this cycle
);

  localparam int             IDX_W = circ_idx_w(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  seq_state_t                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [WORDS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic                       complete_q, complete_d;
  logic                       slip_q, slip_d;

  // Next-state, symbol write and event decode for the collect FSM.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    complete_d = 1'b0;
    slip_d     = 1'b0;
    unique case (state_q)
      HUNT: begin
        if (sync) begin
          state_d = COLLECT;
          idx_d   = '0;
        end
      end
      COLLECT: begin
        // SYNC takes priority over a symbol in the same cycle; the symbol is dropped.
        if (sync) begin
          slip_d = (idx_q != '0);
          idx_d  = '0;
        end else if (byte_vld) begin
          shadow_d[idx_q] = byte_in;
          if (idx_q == LAST) begin
            complete_d = 1'b1;
            idx_d      = '0;
            state_d    = WAIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WAIT: begin
        // A symbol arriving before the next SYNC means we lost frame alignment.
        if (sync) begin
          state_d = COLLECT;
          idx_d   = '0;
        end else if (byte_vld) begin
          slip_d  = 1'b1;
          state_d = HUNT;
        end
      end
      default: begin
        state_d = HUNT;
        idx_d   = '0;
      end
    endcase
  end

  // Collect FSM state, shadow frame and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      idx_q      <= '0;
      shadow_q   <= '0;
      complete_q <= 1'b0;
      slip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      complete_q <= complete_d;
      slip_q     <= slip_d;
    end
  end

  assign shadow   = shadow_q;
  assign complete = complete_q;
  assign slip     = slip_q;
  assign slip_evt = slip_d;

endmodule

// File: rtl/circ_frame_sequencer.sv
// CIRC front-end scheduler: single-entry hold buffer between the assembler and
// the frame-rate pipeline, issue strobe, delay-line fill tracking and frame count.
module circ_frame_sequencer
  import circ_pkg::*;
#(
  parameter int WIDTH       = CIRC_WIDTH,
  parameter int WORDS       = CIRC_WORDS,
  parameter int FILL_FRAMES = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SYNC,
  input  logic [WIDTH-1:0]            BYTE_IN,
  input  logic                        BYTE_VLD,
  input  logic                        BUSY,
  output logic [WORDS-1:0][WIDTH-1:0] FRAME_Q,
  output logic                        FRAME_STB,
  output logic                        PRIMED,
  output logic                        SLIP,
  output logic                        DROP,
  output logic [15:0]                 FRAME_CNT
);

  localparam int            FW       = $clog2(FILL_FRAMES + 2);
  localparam logic [FW-1:0] FILL_MAX = FW'(FILL_FRAMES);

  logic [WORDS-1:0][WIDTH-1:0] shadow;
  logic                        complete, slip, slip_evt;

  circ_frame_assembler #(.WIDTH(WIDTH), .WORDS(WORDS)) u_asm (
    .clk      (CLK),
    .rst      (RST),
    .sync     (SYNC),
    .byte_in  (BYTE_IN),
    .byte_vld (BYTE_VLD),
    .shadow   (shadow),
    .complete (complete),
    .slip     (slip),
    .slip_evt (slip_evt)
  );

  logic [WORDS-1:0][WIDTH-1:0] hold_q, hold_d;
  logic [WORDS-1:0][WIDTH-1:0] out_frame_q, out_frame_d;
  logic                        pending_q, pending_d;
  logic                        stb_q, stb_d;
  logic                        drop_q, drop_d;
  logic                        primed_q, primed_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic [15:0]                 cnt_q, cnt_d;
  logic                        issue;

  // Hold/issue arbitration and fill bookkeeping.
  always_comb begin
    issue       = pending_q && !BUSY;
    hold_d      = hold_q;
    out_frame_d = out_frame_q;
    pending_d   = pending_q;
    stb_d       = 1'b0;
    drop_d      = 1'b0;
    primed_d    = primed_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    if (issue) begin
      out_frame_d = hold_q;
      stb_d       = 1'b1;
      pending_d   = 1'b0;
      cnt_d       = cnt_q + 16'd1;
      primed_d    = (fill_q >= FILL_MAX);
      fill_d      = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + FW'(1);
    end
    // Issuing frees the hold slot in the same cycle, so a completing frame can take it.
    if (complete) begin
      if (!pending_q || issue) begin
        hold_d    = shadow;
        pending_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
    // Any discontinuity invalidates the delay-line contents; restart the fill.
    if (slip_evt || drop_d) begin
      fill_d   = '0;
      primed_d = 1'b0;
    end
  end

  // Hold buffer, issued frame and status registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q      <= '0;
      out_frame_q <= '0;
      pending_q   <= 1'b0;
      stb_q       <= 1'b0;
      drop_q      <= 1'b0;
      primed_q    <= 1'b0;
      fill_q      <= '0;
      cnt_q       <= '0;
    end else begin
      hold_q      <= hold_d;
      out_frame_q <= out_frame_d;
      pending_q   <= pending_d;
      stb_q       <= stb_d;
      drop_q      <= drop_d;
      primed_q    <= primed_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
    end
  end

  assign FRAME_Q   = out_frame_q;
  assign FRAME_STB = stb_q;
  assign PRIMED    = primed_q;
  assign SLIP      = slip;
  assign DROP      = drop_q;
  assign FRAME_CNT = cnt_q;

endmodule
